// File: rtl/dat_phys_if.sv
// dat_phys_if: controller handshake, FIFO ports and DAT line between the DAT controller and the SD PHY.
interface dat_phys_if;
    logic        strobe;
    logic        ack;
    logic [3:0]  blocks;
    logic        write_read;
    logic        multiple;
    logic        serial_ready;
    logic        complete;
    logic        ack_pulse;
    logic [1:0]  error;
    logic [31:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] fifo_din;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic        dat_rx;
    logic        dat_tx;
    logic        dat_oe;

    modport slave (
        input  strobe, ack, blocks, write_read, multiple, fifo_dout, fifo_empty, fifo_full, dat_rx,
        output serial_ready, complete, ack_pulse, error, fifo_rd_en, fifo_din, fifo_wr_en, dat_tx, dat_oe
    );
    modport master (
        output strobe, ack, blocks, write_read, multiple, fifo_dout, fifo_empty, fifo_full, dat_rx,
        input  serial_ready, complete, ack_pulse, error, fifo_rd_en, fifo_din, fifo_wr_en, dat_tx, dat_oe
    );
endinterface

// File: rtl/dat_phys_layer.sv
// dat_phys_layer: SD DAT line PHY; serialises write blocks with CRC16 and status/busy, deserialises read blocks.
module dat_phys_layer #(
    parameter int BLOCK_WORDS = 128,
    parameter int TIMEOUT     = 65535
) (
    input logic clk,
    input logic rst_n,
    dat_phys_if.slave bus
);
    localparam int BITS = BLOCK_WORDS * 32;
    localparam int CW = $clog2(BITS);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(BITS - 1);
    localparam logic [CW-1:0] LAST_WORD = CW'(BITS - 32);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, READY, WR_START, WR_DATA, WR_CRC, WR_END, WR_STATUS, WR_BUSY,
        RD_WAIT, RD_DATA, RD_CRC, RD_END, DONE
    } state_t;

    state_t        state;
    logic          wr;
    logic          got;
    logic [4:0]    blk;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tmo;
    logic [31:0]   word;
    logic [30:0]   sreg;
    logic [15:0]   crc;
    logic [2:0]    status;

    logic        data_bit;
    logic        crc_in;
    logic [15:0] crc_nx;
    logic [1:0]  err_acc;
    logic [1:0]  end_err;
    logic        more;
    logic        tmo_hit;

    // Word 0 of a block only arrives the cycle after its pop, so bit 0 of each word comes straight from the FIFO.
    assign data_bit = cnt[4:0] == 5'd0 ? bus.fifo_dout[31] : word[~cnt[4:0]];
    assign bus.dat_tx = state == WR_START ? 1'b0 : state == WR_DATA ? data_bit : state == WR_CRC ? crc[15] : 1'b1;
    assign crc_in = state == WR_DATA ? data_bit : bus.dat_rx;
    assign crc_nx = {crc[14:0], 1'b0} ^ ((crc[15] ^ crc_in) ? 16'h1021 : 16'h0000);
    assign err_acc = bus.error | {1'b0, (bus.fifo_rd_en && bus.fifo_empty) || (bus.fifo_wr_en && bus.fifo_full)};
    // Running the received CRC through the generator leaves a zero residue when it matches.
    assign end_err = err_acc | {1'b0, state == RD_END && (!bus.dat_rx || crc != 16'h0000)};
    assign more = blk != 5'd1 && end_err == 2'b00;
    assign tmo_hit = tmo == TMO_LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            wr <= 1'b0;
            got <= 1'b0;
            blk <= '0;
            cnt <= '0;
            tmo <= '0;
            word <= '0;
            sreg <= '0;
            crc <= '0;
            status <= '0;
            bus.serial_ready <= 1'b0;
            bus.complete <= 1'b0;
            bus.ack_pulse <= 1'b0;
            bus.error <= 2'b00;
            bus.fifo_rd_en <= 1'b0;
            bus.fifo_din <= '0;
            bus.fifo_wr_en <= 1'b0;
            bus.dat_oe <= 1'b0;
        end else begin
            bus.ack_pulse <= 1'b0;
            bus.fifo_rd_en <= 1'b0;
            bus.fifo_wr_en <= 1'b0;
            bus.error <= err_acc;
            tmo <= '0;
            case (state)
                IDLE: begin
                    state <= READY;
                    bus.serial_ready <= 1'b1;
                end
                READY: if (bus.strobe) begin
                    state <= bus.write_read ? WR_START : RD_WAIT;
                    wr <= bus.write_read;
                    blk <= !bus.multiple ? 5'd1 : bus.blocks == 4'd0 ? 5'd16 : {1'b0, bus.blocks};
                    bus.error <= 2'b00;
                    bus.serial_ready <= 1'b0;
                    bus.dat_oe <= bus.write_read;
                    bus.fifo_rd_en <= bus.write_read;
                end
                WR_START: begin
                    state <= WR_DATA;
                    cnt <= '0;
                    crc <= '0;
                end
                WR_DATA: begin
                    crc <= crc_nx;
                    cnt <= cnt + CW'(1);
                    if (cnt[4:0] == 5'd0) word <= bus.fifo_dout;
                    if (cnt[4:0] == 5'd0 && cnt < LAST_WORD) bus.fifo_rd_en <= 1'b1;
                    if (cnt == LAST_BIT) begin
                        state <= WR_CRC;
                        cnt <= '0;
                    end
                end
                WR_CRC: begin
                    crc <= {crc[14:0], 1'b0};
                    cnt <= cnt + CW'(1);
                    if (cnt[3:0] == 4'd15) state <= WR_END;
                end
                WR_END: begin
                    state <= WR_STATUS;
                    bus.dat_oe <= 1'b0;
                    got <= 1'b0;
                    cnt <= '0;
                end
                WR_STATUS: if (!got) begin
                    if (!bus.dat_rx) got <= 1'b1;
                    else if (tmo_hit) begin
                        state <= DONE;
                        bus.complete <= 1'b1;
                        bus.error <= err_acc | 2'b10;
                    end else tmo <= tmo + TW'(1);
                end else begin
                    cnt <= cnt + CW'(1);
                    if (cnt[1:0] != 2'd3) status <= {status[1:0], bus.dat_rx};
                    else begin
                        state <= WR_BUSY;
                        if (status != 3'b010) bus.error <= err_acc | 2'b01;
                    end
                end
                WR_BUSY, RD_END: if (state == RD_END || bus.dat_rx) begin
                    bus.error <= end_err;
                    blk <= blk - 5'd1;
                    state <= !more ? DONE : wr ? WR_START : RD_WAIT;
                    bus.complete <= !more;
                    bus.dat_oe <= more && wr;
                    bus.fifo_rd_en <= more && wr;
                end else if (tmo_hit) begin
                    state <= DONE;
                    bus.complete <= 1'b1;
                    bus.error <= err_acc | 2'b10;
                end else tmo <= tmo + TW'(1);
                RD_WAIT: begin
                    cnt <= '0;
                    crc <= '0;
                    if (!bus.dat_rx) state <= RD_DATA;
                    else if (tmo_hit) begin
                        state <= DONE;
                        bus.complete <= 1'b1;
                        bus.error <= err_acc | 2'b10;
                    end else tmo <= tmo + TW'(1);
                end
                RD_DATA: begin
                    crc <= crc_nx;
                    cnt <= cnt + CW'(1);
                    sreg <= {sreg[29:0], bus.dat_rx};
                    if (cnt[4:0] == 5'd31) begin
                        bus.fifo_din <= {sreg, bus.dat_rx};
                        bus.fifo_wr_en <= 1'b1;
                    end
                    if (cnt == LAST_BIT) begin
                        state <= RD_CRC;
                        cnt <= '0;
                    end
                end
                RD_CRC: begin
                    crc <= crc_nx;
                    cnt <= cnt + CW'(1);
                    if (cnt[3:0] == 4'd15) state <= RD_END;
                end
                DONE: if (bus.ack) begin
                    bus.ack_pulse <= 1'b1;
                    bus.complete <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dat_phys_layer.sv
// tb_dat_phys_layer: randomized checks of dat_phys_layer against a polynomial-division CRC and frame model.
module tb_dat_phys_layer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dat_phys_if bus();
    dat_phys_layer #(.BLOCK_WORDS(2), .TIMEOUT(100)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int errs = 0;
    int checks = 0;
    logic [31:0] wmem [16];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_pulses = 0;
    logic [31:0] rmem [64];
    int rcnt = 0;

    // Write FIFO with registered read data; read FIFO captures every push.
    assign bus.fifo_empty = rd_ptr == wr_ptr;
    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            rd_pulses <= rd_pulses + 1;
            if (rd_ptr != wr_ptr) begin
                bus.fifo_dout <= wmem[rd_ptr % 16];
                rd_ptr <= rd_ptr + 1;
            end
        end
        if (bus.fifo_wr_en) begin
            rmem[rcnt % 64] <= bus.fifo_din;
            rcnt <= rcnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [15:0] crc_ref(input bit msg[$]);
        bit r[$];
        logic [16:0] p = 17'h11021;
        logic [15:0] c;
        r = msg;
        repeat (16) r.push_back(1'b0);
        for (int i = 0; i < msg.size(); i++)
            if (r[i]) for (int j = 0; j < 17; j++) r[i+j] = r[i+j] ^ p[16-j];
        for (int j = 0; j < 16; j++) c[15-j] = r[msg.size()+j];
        return c;
    endfunction

    function automatic int frame_diff(input bit a[$], input bit b[$]);
        int d = (a.size() == b.size()) ? 0 : 1;
        for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] != b[i]) d++;
        return d;
    endfunction

    task automatic build_frame(input logic [31:0] w0, input logic [31:0] w1, output bit f[$]);
        bit d[$];
        logic [15:0] c;
        for (int i = 31; i >= 0; i--) d.push_back(w0[i]);
        for (int i = 31; i >= 0; i--) d.push_back(w1[i]);
        c = crc_ref(d);
        f = {};
        f.push_back(1'b0);
        foreach (d[i]) f.push_back(d[i]);
        for (int i = 15; i >= 0; i--) f.push_back(c[i]);
        f.push_back(1'b1);
    endtask

    task automatic push_word(input logic [31:0] w);
        wmem[wr_ptr % 16] = w;
        wr_ptr++;
    endtask

    task automatic drive(input bit b[$]);
        foreach (b[i]) begin
            bus.dat_rx = b[i];
            @(negedge clk);
        end
        bus.dat_rx = 1'b1;
    endtask

    task automatic drive_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.dat_rx = v[i];
            @(negedge clk);
        end
        bus.dat_rx = 1'b1;
    endtask

    task automatic start(input bit w, input bit m, input logic [3:0] b);
        int n = 0;
        while (!bus.serial_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.serial_ready !== 1'b1) begin
            errs++;
            $display("FAIL start_ready: serial_ready=%0b want 1", bus.serial_ready);
        end
        bus.write_read = w;
        bus.multiple = m;
        bus.blocks = b;
        bus.strobe = 1'b1;
        @(negedge clk);
        bus.strobe = 1'b0;
    endtask

    task automatic capture(output bit f[$]);
        int n = 0;
        f = {};
        while (bus.dat_oe && n < 200) begin
            f.push_back(bus.dat_tx);
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_complete();
        int n = 0;
        while (!bus.complete && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic finish_ack();
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [8:0] got;
        repeat (2) @(negedge clk);
        got = {bus.dat_oe, bus.dat_tx, bus.serial_ready, bus.complete, bus.error, bus.fifo_rd_en, bus.fifo_wr_en, bus.ack_pulse};
        checks++;
        if (got !== 9'b0_1_0_0_00_0_0_0) begin errs++; $display("FAIL reset_outputs: got %b want 010000000", got); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.serial_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: serial_ready=%0b want 1", bus.serial_ready); end
    endtask

    task automatic test_write();
        bit f[$], e[$];
        int p0 = rd_pulses;
        push_word(32'hA5A50F0F);
        push_word(32'h12345678);
        build_frame(32'hA5A50F0F, 32'h12345678, e);
        start(1'b1, 1'b0, 4'd0);
        capture(f);
        checks++;
        if (f.size() != 82) begin errs++; $display("FAIL write_len: oe cycles=%0d want 82", f.size()); end
        checks++;
        if (frame_diff(f, e) != 0) begin errs++; $display("FAIL write_frame: %0d bit differences want 0", frame_diff(f, e)); end
        checks++;
        if (rd_pulses - p0 != 2) begin errs++; $display("FAIL write_pops: %0d want 2", rd_pulses - p0); end
        checks++;
        if (bus.complete !== 1'b0) begin errs++; $display("FAIL write_early_complete: %0b want 0", bus.complete); end
        drive_bits(32'h0A0, 10);
        wait_complete();
        checks++;
        if ({bus.complete, bus.error} !== 3'b100) begin errs++; $display("FAIL write_done: complete,error=%b want 100", {bus.complete, bus.error}); end
        finish_ack();
    endtask

    task automatic test_read_multi();
        logic [31:0] exp_w[$];
        bit f[$];
        int base = rcnt;
        start(1'b0, 1'b1, 4'd3);
        for (int b = 0; b < 3; b++) begin
            logic [31:0] w0 = $urandom;
            logic [31:0] w1 = $urandom;
            exp_w.push_back(w0);
            exp_w.push_back(w1);
            build_frame(w0, w1, f);
            drive_bits(32'hFFFFFFFF, $urandom_range(1, 8));
            drive(f);
            if (b == 0) begin
                checks++;
                if (bus.complete !== 1'b0) begin errs++; $display("FAIL read_mid_complete: %0b want 0", bus.complete); end
            end
        end
        checks++;
        if (bus.complete !== 1'b1) begin errs++; $display("FAIL read_complete: %0b want 1", bus.complete); end
        checks++;
        if (rcnt - base != 6) begin errs++; $display("FAIL read_pushes: %0d want 6", rcnt - base); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (rmem[(base + i) % 64] !== exp_w[i]) begin
                errs++;
                $display("FAIL read_word%0d: got %h want %h", i, rmem[(base + i) % 64], exp_w[i]);
            end
        end
        checks++;
        if (bus.error !== 2'b00) begin errs++; $display("FAIL read_error: %b want 00", bus.error); end
        bus.ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.ack_pulse, bus.complete} !== 2'b10) begin errs++; $display("FAIL ack_pulse: ack,complete=%b want 10", {bus.ack_pulse, bus.complete}); end
        bus.ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.ack_pulse, bus.serial_ready} !== 2'b01) begin errs++; $display("FAIL ack_single: ack,ready=%b want 01", {bus.ack_pulse, bus.serial_ready}); end
    endtask

    task automatic test_read_crc_err();
        bit f[$];
        int n;
        int idx = $urandom_range(0, 15);
        build_frame($urandom, $urandom, f);
        f[65 + idx] = ~f[65 + idx];
        start(1'b0, 1'b1, 4'd2);
        drive_bits(32'hFFFFFFFF, 3);
        drive(f);
        checks++;
        if ({bus.complete, bus.error} !== 3'b101) begin errs++; $display("FAIL crc_err: complete,error=%b want 101", {bus.complete, bus.error}); end
        n = rcnt;
        build_frame($urandom, $urandom, f);
        drive(f);
        checks++;
        if (rcnt != n || bus.complete !== 1'b1) begin errs++; $display("FAIL crc_abort: extra pushes=%0d complete=%0b want 0,1", rcnt - n, bus.complete); end
        finish_ack();
    endtask

    task automatic test_bad_status();
        bit f[$];
        push_word($urandom);
        push_word($urandom);
        start(1'b1, 1'b0, 4'd0);
        capture(f);
        drive_bits(32'h0B, 5);
        wait_complete();
        checks++;
        if ({bus.complete, bus.error} !== 3'b101) begin errs++; $display("FAIL bad_status: complete,error=%b want 101", {bus.complete, bus.error}); end
        finish_ack();
    endtask

    task automatic test_write_timeout();
        bit f[$];
        int n = 0;
        push_word($urandom);
        push_word($urandom);
        start(1'b1, 1'b0, 4'd0);
        capture(f);
        while (!bus.error[1] && n < 150) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 100) begin errs++; $display("FAIL timeout_cycles: %0d want 100", n); end
        checks++;
        if ({bus.complete, bus.error} !== 3'b110) begin errs++; $display("FAIL timeout_state: complete,error=%b want 110", {bus.complete, bus.error}); end
        finish_ack();
    endtask

    task automatic test_fifo_empty();
        bit f[$], e[$];
        logic [31:0] w0 = $urandom;
        int p0 = rd_pulses;
        push_word(w0);
        build_frame(w0, w0, e);
        start(1'b1, 1'b0, 4'd0);
        capture(f);
        checks++;
        if (f.size() != 82 || frame_diff(f, e) != 0) begin errs++; $display("FAIL empty_frame: len=%0d diffs=%0d want 82,0", f.size(), frame_diff(f, e)); end
        checks++;
        if (rd_pulses - p0 != 2) begin errs++; $display("FAIL empty_pops: %0d want 2", rd_pulses - p0); end
        drive_bits(32'h0A0, 10);
        wait_complete();
        checks++;
        if ({bus.complete, bus.error} !== 3'b101) begin errs++; $display("FAIL empty_done: complete,error=%b want 101", {bus.complete, bus.error}); end
        finish_ack();
    endtask

    task automatic test_reset_mid();
        push_word($urandom);
        push_word($urandom);
        start(1'b1, 1'b0, 4'd0);
        repeat (20) @(negedge clk);
        checks++;
        if (bus.dat_oe !== 1'b1) begin errs++; $display("FAIL mid_oe: %0b want 1", bus.dat_oe); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.dat_oe, bus.dat_tx, bus.complete} !== 3'b010) begin errs++; $display("FAIL mid_reset: oe,tx,complete=%b want 010", {bus.dat_oe, bus.dat_tx, bus.complete}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.serial_ready !== 1'b1) begin errs++; $display("FAIL mid_ready: %0b want 1", bus.serial_ready); end
    endtask

    initial begin
        bus.strobe = 1'b0;
        bus.ack = 1'b0;
        bus.blocks = 4'd0;
        bus.write_read = 1'b0;
        bus.multiple = 1'b0;
        bus.fifo_full = 1'b0;
        bus.dat_rx = 1'b1;
        test_reset();
        test_write();
        test_read_multi();
        test_read_crc_err();
        test_bad_status();
        test_write_timeout();
        test_fifo_empty();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
